// File: rtl/upsample_layer_scheduler_pkg.sv
// Shared definitions for the upsample layer scheduler and the upsample core:
// FSM states, error codes, size codes and the per-channel word-count shift.
package upsample_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ADVANCE,
      S_FINISH,
      S_FAULT
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_SIZE    = 2'd1;
   localparam logic [1:0] ERR_ZERO_CH = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [2:0] SIZE_4   = 3'd0;
   localparam logic [2:0] SIZE_8   = 3'd1;
   localparam logic [2:0] SIZE_16  = 3'd2;
   localparam logic [2:0] SIZE_32  = 3'd3;
   localparam logic [2:0] SIZE_64  = 3'd4;
   localparam logic [2:0] SIZE_MAX = 3'd4;

   // N*N for input side N = 4 << size, i.e. 16 << (2*size); shift only.
   function automatic logic [31:0] nn_words(input logic [2:0] size);
      return 32'd16 << {size, 1'b0};
   endfunction

endpackage

// File: rtl/upsample_layer_scheduler_watchdog.sv
// Loadable up-counter with clear and enable; tc flags the terminal count TIMEOUT.
module upsample_watchdog #(
   parameter int unsigned TIMEOUT = 65535,
   parameter int unsigned W       = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == W'(TIMEOUT));

endmodule

// File: rtl/upsample_layer_scheduler.sv
// Runs the 2x upsample core once per channel of a layer, stepping the channel
// base addresses and guarding each core run with a watchdog.
module upsample_layer_scheduler
   import upsample_pkg::*;
#(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned CH_W    = 9,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_size,
   input  logic [CH_W-1:0]   cmd_channels,
   input  logic [ADDR_W-1:0] cmd_src_base,
   input  logic [ADDR_W-1:0] cmd_dst_base,
   output logic              core_start,
   output logic [2:0]        core_size,
   input  logic              core_done,
   output logic [ADDR_W-1:0] ch_src_base,
   output logic [ADDR_W-1:0] ch_dst_base,
   output logic [CH_W-1:0]   ch_index,
   output logic              busy,
   output logic              layer_done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   state_t            state;
   logic [CH_W-1:0]   channels_q;
   logic [ADDR_W-1:0] src_stride;
   logic [ADDR_W-1:0] dst_stride;
   logic              wd_tc;

   assign cmd_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign src_stride = ADDR_W'(nn_words(core_size));
   assign dst_stride = src_stride << 2;

   // Loaded with 1 in ISSUE so the issue cycle counts toward the budget:
   // a core that never answers faults TIMEOUT+1 cycles after core_start.
   upsample_watchdog #(
      .TIMEOUT (TIMEOUT),
      .W       (WD_W)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == S_IDLE),
      .load     (state == S_ISSUE),
      .load_val (WD_W'(1)),
      .en       (state == S_WAIT),
      .tc       (wd_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         core_start  <= 1'b0;
         layer_done  <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_NONE;
         ch_index    <= '0;
         ch_src_base <= '0;
         ch_dst_base <= '0;
         core_size   <= '0;
         channels_q  <= '0;
      end else begin
         core_start <= 1'b0;
         layer_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  core_size   <= cmd_size;
                  channels_q  <= cmd_channels;
                  ch_src_base <= cmd_src_base;
                  ch_dst_base <= cmd_dst_base;
                  ch_index    <= '0;
                  err_code    <= ERR_NONE;
                  if (cmd_size > SIZE_MAX) begin
                     state    <= S_FAULT;
                     err      <= 1'b1;
                     err_code <= ERR_SIZE;
                  end else if (cmd_channels == '0) begin
                     state    <= S_FAULT;
                     err      <= 1'b1;
                     err_code <= ERR_ZERO_CH;
                  end else begin
                     state      <= S_ISSUE;
                     core_start <= 1'b1;
                  end
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (core_done) begin
                  state <= S_ADVANCE;
               end else if (wd_tc) begin
                  state    <= S_FAULT;
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end
            end
            S_ADVANCE: begin
               if (ch_index == channels_q - CH_W'(1)) begin
                  state      <= S_FINISH;
                  layer_done <= 1'b1;
               end else begin
                  ch_index    <= ch_index + CH_W'(1);
                  ch_src_base <= ch_src_base + src_stride;
                  ch_dst_base <= ch_dst_base + dst_stride;
                  state       <= S_ISSUE;
                  core_start  <= 1'b1;
               end
            end
            S_FINISH: state <= S_IDLE;
            S_FAULT:  state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_upsample_layer_scheduler.sv
// Bench for upsample_layer_scheduler: command table, randomized layers and a
// mid-layer reset, all checked against a simple address/timing model.
module tb_upsample_layer_scheduler;
   import upsample_pkg::*;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_size;
   logic [8:0]  cmd_channels;
   logic [19:0] cmd_src_base;
   logic [19:0] cmd_dst_base;
   logic        core_start;
   logic [2:0]  core_size;
   logic        core_done;
   logic [19:0] ch_src_base;
   logic [19:0] ch_dst_base;
   logic [8:0]  ch_index;
   logic        busy;
   logic        layer_done;
   logic        err;
   logic [1:0]  err_code;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   upsample_layer_scheduler #(
      .ADDR_W  (20),
      .CH_W    (9),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_size     (cmd_size),
      .cmd_channels (cmd_channels),
      .cmd_src_base (cmd_src_base),
      .cmd_dst_base (cmd_dst_base),
      .core_start   (core_start),
      .core_size    (core_size),
      .core_done    (core_done),
      .ch_src_base  (ch_src_base),
      .ch_dst_base  (ch_dst_base),
      .ch_index     (ch_index),
      .busy         (busy),
      .layer_done   (layer_done),
      .err          (err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Core model: done pulses core_lat cycles after the cycle core_start is seen.
   int   core_lat    = 10;
   bit   core_en     = 1'b0;
   int   core_cnt    = -1;
   logic model_done  = 1'b0;
   logic manual_done = 1'b0;
   assign core_done = model_done | manual_done;

   always @(negedge clk) begin
      model_done = 1'b0;
      if (!core_en) core_cnt = -1;
      else if (core_start) core_cnt = core_lat;
      else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) model_done = 1'b1;
      end
   end

   // Observed start pulses and completion pulses.
   logic [19:0] q_src[$];
   logic [19:0] q_dst[$];
   int          q_idx[$];
   int          q_sz[$];
   int          q_cyc[$];
   int          ld_cnt = 0, ld_cyc = 0, err_cnt = 0, err_cyc = 0;

   always @(negedge clk) begin
      if (core_start) begin
         q_src.push_back(ch_src_base);
         q_dst.push_back(ch_dst_base);
         q_idx.push_back(int'(ch_index));
         q_sz.push_back(int'(core_size));
         q_cyc.push_back(cyc);
      end
      if (layer_done) begin ld_cnt++; ld_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [19:0] m_src(input logic [19:0] b, input logic [2:0] sz, input int i);
      int n;
      n = 4 << sz;
      return 20'(b + i * n * n);
   endfunction

   function automatic logic [19:0] m_dst(input logic [19:0] b, input logic [2:0] sz, input int i);
      int n;
      n = 4 << sz;
      return 20'(b + i * 4 * n * n);
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_layer_done"}, layer_done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_err_code"}, err_code, 0);
      chk({tag, "_ch_index"}, ch_index, 0);
      chk({tag, "_ch_src"}, ch_src_base, 0);
      chk({tag, "_ch_dst"}, ch_dst_base, 0);
      chk({tag, "_core_size"}, core_size, 0);
   endtask

   task automatic run_cmd(input logic [2:0] sz, input logic [8:0] ch, input logic [19:0] src,
                          input logic [19:0] dst, input int lat, input bit hang);
      int q0, ld0, er0, w, budget, n, lastc;
      logic [1:0] ecode;
      ecode = (sz > 3'd4) ? 2'd1 : (ch == 9'd0) ? 2'd2 : hang ? 2'd3 : 2'd0;
      n = (ecode == 2'd1 || ecode == 2'd2) ? 0 : (hang ? 1 : int'(ch));
      core_lat = lat;
      core_en  = !hang;
      w = 0;
      while (!cmd_ready && w < 500) begin @(negedge clk); w++; end
      chk("idle_ready", cmd_ready, 1);
      #1;
      q0 = q_src.size(); ld0 = ld_cnt; er0 = err_cnt;
      cmd_valid = 1'b1; cmd_size = sz; cmd_channels = ch;
      cmd_src_base = src; cmd_dst_base = dst;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_size = 3'($urandom); cmd_channels = 9'($urandom);
      cmd_src_base = 20'($urandom); cmd_dst_base = 20'($urandom);
      @(negedge clk);
      if (n == 0) begin
         chk("rej_err", err, 1);
         chk("rej_code", err_code, ecode);
         chk("rej_no_start", core_start, 0);
         chk("rej_not_ready", cmd_ready, 0);
         @(negedge clk);
         chk("rej_ready_back", cmd_ready, 1);
         chk("rej_err_pulse", err, 0);
      end else begin
         chk("acc_start", core_start, 1);
         chk("acc_busy", busy, 1);
         chk("acc_code_clr", err_code, 0);
         chk("acc_index", ch_index, 0);
         chk("acc_src", ch_src_base, src);
         chk("acc_dst", ch_dst_base, dst);
         chk("acc_size", core_size, sz);
         budget = n * (lat + 4) + (hang ? TO + 20 : 0) + 10;
         w = 0;
         while (ld_cnt == ld0 && err_cnt == er0 && w < budget) begin
            @(negedge clk); #1; w++;
         end
         chk("finish_in_budget", (w < budget), 1);
      end
      repeat (3) @(negedge clk);
      #1;
      chk("start_count", q_src.size() - q0, n);
      for (int i = 0; i < n && i < q_src.size() - q0; i++) begin
         chk("ch_src", q_src[q0+i], m_src(src, sz, i));
         chk("ch_dst", q_dst[q0+i], m_dst(dst, sz, i));
         chk("ch_idx", q_idx[q0+i], i);
         chk("ch_size", q_sz[q0+i], int'(sz));
         if (i > 0) chk("start_gap", q_cyc[q0+i] - q_cyc[q0+i-1], lat + 2);
      end
      if (ecode == 2'd0) begin
         chk("ld_pulses", ld_cnt - ld0, 1);
         chk("ok_no_err", err_cnt - er0, 0);
         lastc = (q_cyc.size() > q0) ? q_cyc[q_cyc.size()-1] : 0;
         chk("ld_latency", ld_cyc - lastc, lat + 2);
      end else begin
         chk("fault_no_ld", ld_cnt - ld0, 0);
         chk("err_pulses", err_cnt - er0, 1);
         if (hang && q_cyc.size() > q0) chk("timeout_latency", err_cyc - q_cyc[q0], TO + 1);
      end
      chk("end_code", err_code, ecode);
      chk("end_idle", busy, 0);
   endtask

   typedef struct {
      logic [2:0]  sz;
      logic [8:0]  ch;
      logic [19:0] src;
      logic [19:0] dst;
      int          lat;
      bit          hang;
      logic [1:0]  code;
      int          nst;
      logic [19:0] lsrc;
      logic [19:0] ldst;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int q0, w;
      tbl[0] = '{SIZE_4,  9'd3, 20'h00100, 20'h04000, 70, 1'b0, 2'd0, 3, 20'h00120, 20'h04080};
      tbl[1] = '{SIZE_64, 9'd2, 20'hFF000, 20'hFC000, 12, 1'b0, 2'd0, 2, 20'h00000, 20'h00000};
      tbl[2] = '{3'd5,    9'd1, 20'h00200, 20'h00300, 10, 1'b0, 2'd1, 0, 20'h00000, 20'h00000};
      tbl[3] = '{SIZE_16, 9'd0, 20'h00200, 20'h00300, 10, 1'b0, 2'd2, 0, 20'h00000, 20'h00000};
      tbl[4] = '{SIZE_8,  9'd1, 20'hABCDE, 20'h12345,  5, 1'b0, 2'd0, 1, 20'hABCDE, 20'h12345};
      tbl[5] = '{SIZE_32, 9'd2, 20'h00010, 20'h00020, 10, 1'b1, 2'd3, 1, 20'h00010, 20'h00020};

      rst = 1'b0; cmd_valid = 1'b0; cmd_size = '0; cmd_channels = '0;
      cmd_src_base = '0; cmd_dst_base = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         q0 = q_src.size();
         run_cmd(tbl[k].sz, tbl[k].ch, tbl[k].src, tbl[k].dst, tbl[k].lat, tbl[k].hang);
         chk("tbl_code", err_code, tbl[k].code);
         chk("tbl_starts", q_src.size() - q0, tbl[k].nst);
         if (tbl[k].nst > 0 && q_src.size() >= q0 + tbl[k].nst) begin
            chk("tbl_last_src", q_src[q0+tbl[k].nst-1], tbl[k].lsrc);
            chk("tbl_last_dst", q_dst[q0+tbl[k].nst-1], tbl[k].ldst);
         end
      end

      for (int r = 0; r < 10; r++) begin
         run_cmd(3'($urandom_range(0, 6)), 9'($urandom_range(0, 5)),
                 20'($urandom), 20'($urandom), int'($urandom_range(2, 15)), 1'b0);
      end

      // Reset while channel 1 of 4 is waiting on the core.
      core_lat = 40; core_en = 1'b1;
      @(negedge clk);
      q0 = q_src.size();
      cmd_valid = 1'b1; cmd_size = SIZE_8; cmd_channels = 9'd4;
      cmd_src_base = 20'h00500; cmd_dst_base = 20'h09000;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      w = 0;
      while (q_src.size() - q0 < 2 && w < 300) begin @(negedge clk); #1; w++; end
      chk("mid_second_start", (w < 300), 1);
      repeat (5) @(negedge clk);
      chk("mid_index", ch_index, 1);
      chk("mid_busy", busy, 1);
      core_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      q0 = q_src.size();
      w = ld_cnt;
      rst = 1'b1;
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("spurious_no_ld", ld_cnt - w, 0);
      chk("spurious_idle", busy, 0);
      chk("spurious_no_start", q_src.size() - q0, 0);
      run_cmd(SIZE_8, 9'd3, 20'h00700, 20'h0A000, 8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
